// File: rtl/mult_18x18_acc_if.sv
// Handshake bundle between a product source and the 18x18 accumulator.
// The master drives products and controls; the slave returns the result.
interface mult_18x18_acc_if;
  logic        mode;
  logic        in_valid;
  logic [35:0] in_Y;
  logic        acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic [47:0] acc_out;
  logic [1:0]  ovf;

  modport master (
    output mode, in_valid, in_Y,
    output acc_en, acc_clr,
    input  out_valid, acc_out, ovf
  );

  modport slave (
    input  mode, in_valid, in_Y,
    input  acc_en, acc_clr,
    output out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mult_18x18_acc.sv
// Two-stage 48-bit / dual 24-bit accumulator behind an 18x18 multiplier.
// Define MULT_18X18_ACC_SATURATE_EN to clamp on overflow instead of wrap.
module mult_18x18_acc (
  input logic             clk,
  input logic             reset,
  mult_18x18_acc_if.slave bus
);

  logic        s1_vld_q;
  logic        s1_clr_q;
  logic        s1_mode_q;
  logic        s1_en_q;
  logic [35:0] s1_y_q;

  logic [47:0] acc_q, acc_d;
  logic [1:0]  ovf_q, ovf_d;
  logic        vld_q, vld_d;

  logic [47:0] base;
  logic [48:0] wide;
  logic [24:0] lo;
  logic [24:0] hi;

  // Returns {overflow, sum}; sum is clamped when saturation is built in.
  function automatic logic [24:0] add24(
    input logic [23:0] a,
    input logic [23:0] b
  );
    logic [23:0] s;
    logic        v;
    s = a + b;
    v = (a[23] == b[23]) && (s[23] != a[23]);
`ifdef MULT_18X18_ACC_SATURATE_EN
    if (v) s = a[23] ? 24'h800000 : 24'h7FFFFF;
`endif
    return {v, s};
  endfunction

  function automatic logic [48:0] add48(
    input logic [47:0] a,
    input logic [47:0] b
  );
    logic [47:0] s;
    logic        v;
    s = a + b;
    v = (a[47] == b[47]) && (s[47] != a[47]);
`ifdef MULT_18X18_ACC_SATURATE_EN
    if (v) s = a[47] ? {1'b1, 47'd0} : {1'b0, {47{1'b1}}};
`endif
    return {v, s};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_clr_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_y_q    <= '0;
    end else begin
      s1_vld_q <= bus.in_valid;
      s1_clr_q <= bus.acc_clr;
      if (bus.in_valid || bus.acc_clr) begin
        s1_mode_q <= bus.mode;
        s1_en_q   <= bus.acc_en;
        s1_y_q    <= bus.in_Y;
      end
    end
  end

  // Clear or load both start from zero, so clear+valid yields the product.
  always_comb begin
    base = (s1_clr_q || !s1_en_q) ? '0 : acc_q;
    wide = add48(base, {{12{s1_y_q[35]}}, s1_y_q});
    lo   = add24(base[23:0],
                 {{6{s1_y_q[17]}}, s1_y_q[17:0]});
    hi   = add24(base[47:24],
                 {{6{s1_y_q[35]}}, s1_y_q[35:18]});
    acc_d = acc_q;
    ovf_d = ovf_q;
    vld_d = 1'b0;
    if (s1_clr_q) begin
      acc_d = '0;
      ovf_d = '0;
    end
    if (s1_vld_q) begin
      vld_d = 1'b1;
      if (s1_mode_q) begin
        acc_d = {hi[23:0], lo[23:0]};
        ovf_d = ovf_d | {hi[24], lo[24]};
      end else begin
        acc_d    = wide[47:0];
        ovf_d[0] = ovf_d[0] | wide[48];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = vld_q;

endmodule
